// File: rtl/imem_pkg.sv
// Shared types and default sizes for the instruction fetch port.
package imem_pkg;

  localparam int IMEM_DEPTH       = 2048;
  localparam int IMEM_FETCH_BYTES = 10;
  localparam int IMEM_AW          = 64;

  // Occupancy of the two-entry response skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Response record at the default geometry; the top redefines it for its own parameters
  typedef struct packed {
    logic [IMEM_AW-1:0]                  pc;
    logic [7:0]                          byte0;
    logic [8*(IMEM_FETCH_BYTES-1)-1:0]   bytes;
    logic                                imem_error;
  } imem_rsp_t;

endpackage

// File: rtl/imem_skid_buf.sv
// Two-entry valid/ready skid buffer with flush. The output register holds the
// head response; the skid register catches one extra response while stalled.
module imem_skid_buf
  import imem_pkg::*;
#(
  parameter type T = imem_rsp_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic in_ready,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready
);

  skid_state_e state_q;
  T            out_p1;
  T            skid_p1;
  logic        accept;

  assign in_ready  = (state_q != TWO) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_p1;

  // Occupancy tracking; flush empties the buffer ahead of any other event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_q <= ONE;
        ONE: begin
          if (accept && !out_ready)      state_q <= TWO;
          else if (!accept && out_ready) state_q <= EMPTY;
        end
        TWO:     if (out_ready) state_q <= ONE;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // ---- stage p1: output register, cleared on reset so idle outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
    end else if (!flush) begin
      if ((state_q == EMPTY && accept) || (state_q == ONE && accept && out_ready))
        out_p1 <= in_data;
      else if (state_q == TWO && out_ready)
        out_p1 <= skid_p1;
    end
  end

  // Skid register only captures when the head is stalled and a new response arrives
  always_ff @(posedge clk) begin
    if (state_q == ONE && accept && !out_ready)
      skid_p1 <= in_data;
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory fetch port: byte-addressed program store with a byte load
// port, returning an instruction window one cycle after an accepted request.
// Optional build macro: IMEM_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int DEPTH       = IMEM_DEPTH,
  parameter int FETCH_BYTES = IMEM_FETCH_BYTES,
  parameter int AW          = IMEM_AW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_en,
  input  logic [AW-1:0]                ld_addr,
  input  logic [7:0]                   ld_data,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [AW-1:0]                req_pc,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [AW-1:0]                rsp_pc,
  output logic [7:0]                   rsp_byte0,
  output logic [8*(FETCH_BYTES-1)-1:0] rsp_bytes,
  output logic                         rsp_imem_error
`ifdef IMEM_PERF_CNT_EN
  ,output logic [31:0]                 fetch_cnt
  ,output logic [31:0]                 stall_cnt
`endif
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          BW      = 8 * (FETCH_BYTES - 1);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [7:0]    byte0;
    logic [BW-1:0] bytes;
    logic          imem_error;
  } rsp_t;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] win_addr;
  logic [7:0]  win_p0 [FETCH_BYTES];
  logic        err_p0;
  rsp_t        rsp_p0;
  rsp_t        rsp_p1;
  logic        vld_p1;
  logic        accept;

  assign accept = req_valid & req_ready;

  // Byte load port; addresses past the store are silently ignored
  always_ff @(posedge clk) begin
    if (ld_en && ({1'b0, ld_addr} < DEPTH_X))
      mem[ld_addr[IW-1:0]] <= ld_data;
  end

  // ---- stage p0: read the window combinationally; widened add keeps pc+i from wrapping
  always_comb begin
    win_addr = '0;
    win_p0   = '{default: 8'h00};
    for (int i = 0; i < FETCH_BYTES; i++) begin
      win_addr  = {1'b0, req_pc} + (AW+1)'(i);
      win_p0[i] = (win_addr < DEPTH_X) ? mem[win_addr[IW-1:0]] : 8'h00;
    end
  end

  assign err_p0 = ({1'b0, req_pc} >= DEPTH_X);

  // Pack the response; an out-of-range pc returns all-zero bytes so decode sees a nop
  always_comb begin
    rsp_p0            = '0;
    rsp_p0.pc         = req_pc;
    rsp_p0.imem_error = err_p0;
    if (!err_p0) begin
      rsp_p0.byte0 = win_p0[0];
      for (int i = 1; i < FETCH_BYTES; i++)
        rsp_p0.bytes[8*(FETCH_BYTES-1-i) +: 8] = win_p0[i];
    end
  end

  // ---- stage p1: captured window held in the skid buffer until consumed
  imem_skid_buf #(
    .T(rsp_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (req_valid),
    .in_data   (rsp_p0),
    .in_ready  (req_ready),
    .out_valid (vld_p1),
    .out_data  (rsp_p1),
    .out_ready (rsp_ready)
  );

  assign rsp_valid      = vld_p1;
  assign rsp_pc         = rsp_p1.pc;
  assign rsp_byte0      = rsp_p1.byte0;
  assign rsp_bytes      = rsp_p1.bytes;
  assign rsp_imem_error = rsp_p1.imem_error;

`ifdef IMEM_PERF_CNT_EN
  // Accepted-fetch counter, saturating, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             fetch_cnt <= '0;
    else if (flush)                         fetch_cnt <= '0;
    else if (accept && fetch_cnt != '1)     fetch_cnt <= fetch_cnt + 32'd1;
  end

  // Back-pressure counter: cycles a response waits on the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            stall_cnt <= '0;
    else if (flush)                                        stall_cnt <= '0;
    else if (vld_p1 && !rsp_ready && stall_cnt != '1)      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_imem_fetch_port;

  localparam int DEPTH = 2048;
  localparam int FB    = 10;
  localparam int AW    = 64;
  localparam int BW    = 8 * (FB - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_pc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_pc;
  logic [7:0]    rsp_byte0;
  logic [BW-1:0] rsp_bytes;
  logic          rsp_imem_error;

  imem_fetch_port #(.DEPTH(DEPTH), .FETCH_BYTES(FB), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_pc         (rsp_pc),
    .rsp_byte0      (rsp_byte0),
    .rsp_bytes      (rsp_bytes),
    .rsp_imem_error (rsp_imem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [7:0]    b0;
    logic [BW-1:0] bytes;
    logic          err;
  } resp_t;

  logic [7:0] mm [DEPTH];
  resp_t      q[$];
  int         total = 0;
  int         bad   = 0;
  resp_t      tab[8];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [AW:0] a);
    if (a < (AW+1)'(DEPTH)) return mm[int'(a)];
    return 8'h00;
  endfunction

  // Expected response straight from the window rules
  function automatic resp_t mk_exp(input logic [AW-1:0] pc);
    resp_t e;
    e.pc    = pc;
    e.err   = (pc >= AW'(DEPTH));
    e.b0    = 8'h00;
    e.bytes = '0;
    if (!e.err) begin
      e.b0 = byte_at({1'b0, pc});
      for (int i = 1; i < FB; i++)
        e.bytes = (e.bytes << 8) | BW'(byte_at({1'b0, pc} + (AW+1)'(i)));
    end
    return e;
  endfunction

  // One clock: check outputs against the model, then advance the model at the edge
  task automatic cycle();
    resp_t e;
    logic  acc, pop, fl, le;
    logic [AW-1:0] la;
    logic [7:0] ldv;
    #1;
    chk("rsp_valid", 80'(rsp_valid), 80'(q.size() != 0));
    chk("req_ready", 80'(req_ready), 80'((q.size() < 2) && !flush));
    if (q.size() != 0 && rsp_valid) begin
      chk("rsp_pc",    80'(rsp_pc),         80'(q[0].pc));
      chk("rsp_byte0", 80'(rsp_byte0),      80'(q[0].b0));
      chk("rsp_bytes", 80'(rsp_bytes),      80'(q[0].bytes));
      chk("rsp_err",   80'(rsp_imem_error), 80'(q[0].err));
    end
    fl  = flush;
    acc = req_valid && (q.size() < 2) && !flush;
    pop = rsp_ready && (q.size() != 0);
    e   = mk_exp(req_pc);
    le  = ld_en; la = ld_addr; ldv = ld_data;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (le && la < AW'(DEPTH)) mm[int'(la)] = ldv;
    @(negedge clk);
  endtask

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      111:  return 8'h77;
      112:  return 8'h30;
      113:  return 8'hF8;
      114:  return 8'h08;
      143:  return 8'h00;
      2045: return 8'h5C;
      2046: return 8'hAB;
      2047: return 8'h00;
      default: begin
        if (a < 10) return 8'((a + 1) * 17);
        if (a >= 115 && a <= 121) return 8'h00;
        return 8'($urandom);
      end
    endcase
  endfunction

  initial begin
    tab[0] = '{pc: 64'd0,    b0: 8'h11, bytes: 72'h22_33_44_55_66_77_88_99_AA, err: 1'b0};
    tab[1] = '{pc: 64'd111,  b0: 8'h77, bytes: 72'h30_F8_08_00_00_00_00_00_00, err: 1'b0};
    tab[2] = '{pc: 64'd112,  b0: 8'h30, bytes: 72'hF8_08_00_00_00_00_00_00_00, err: 1'b0};
    tab[3] = '{pc: 64'd2045, b0: 8'h5C, bytes: 72'hAB_00_00_00_00_00_00_00_00, err: 1'b0};
    tab[4] = '{pc: 64'd2046, b0: 8'hAB, bytes: 72'h0, err: 1'b0};
    tab[5] = '{pc: 64'd2047, b0: 8'h00, bytes: 72'h0, err: 1'b0};
    tab[6] = '{pc: 64'd2048, b0: 8'h00, bytes: 72'h0, err: 1'b1};
    tab[7] = '{pc: 64'hFFFF_FFFF_FFFF_FFFF, b0: 8'h00, bytes: 72'h0, err: 1'b1};

    rst_n = 1'b1; ld_en = 0; ld_addr = '0; ld_data = '0; flush = 0;
    req_valid = 0; req_pc = '0; rsp_ready = 0;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_rsp_valid", 80'(rsp_valid),      80'(0));
    chk("rst_rsp_pc",    80'(rsp_pc),         80'(0));
    chk("rst_byte0",     80'(rsp_byte0),      80'(0));
    chk("rst_bytes",     80'(rsp_bytes),      80'(0));
    chk("rst_err",       80'(rsp_imem_error), 80'(0));
    chk("rst_req_ready", 80'(req_ready),      80'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole store, then try loads that land outside it
    ld_en = 1;
    for (int a = 0; a < DEPTH; a++) begin
      ld_addr = AW'(a); ld_data = init_byte(a);
      cycle();
    end
    ld_data = 8'hEE;
    ld_addr = 64'd2048;             cycle();
    ld_addr = 64'd2049;             cycle();
    ld_addr = 64'hFFFF_FFFF_FFFF_FFFF; cycle();
    ld_en = 0;

    // Directed windows
    for (int k = 0; k < 8; k++) begin
      req_valid = 1; req_pc = tab[k].pc; rsp_ready = 1;
      cycle();
      req_valid = 0;
      #1;
      chk("tab_valid", 80'(rsp_valid),      80'(1));
      chk("tab_pc",    80'(rsp_pc),         80'(tab[k].pc));
      chk("tab_byte0", 80'(rsp_byte0),      80'(tab[k].b0));
      chk("tab_bytes", 80'(rsp_bytes),      80'(tab[k].bytes));
      chk("tab_err",   80'(rsp_imem_error), 80'(tab[k].err));
      cycle();
    end

    // Back-to-back requests under a stalled consumer
    rsp_ready = 0; req_valid = 1; req_pc = 64'd122; cycle();
    req_pc = 64'd132; cycle();
    req_pc = 64'd140;
    #1;
    chk("s3_ready_low", 80'(req_ready), 80'(0));
    chk("s3_hold_pc",   80'(rsp_pc),    80'(122));
    cycle(); cycle();
    #1 chk("s3_hold_pc2", 80'(rsp_pc), 80'(122));
    req_valid = 0; rsp_ready = 1;
    #1 chk("s3_first", 80'(rsp_pc), 80'(122));
    cycle();
    #1;
    chk("s3_second",  80'(rsp_pc),    80'(132));
    chk("s3_second_v", 80'(rsp_valid), 80'(1));
    cycle();
    #1 chk("s3_drained", 80'(rsp_valid), 80'(0));

    // Flush while full, with a request presented at the same time
    rsp_ready = 0; req_valid = 1; req_pc = 64'd150; cycle();
    req_pc = 64'd160; cycle();
    flush = 1; req_pc = 64'd145;
    #1 chk("s4_ready_flush", 80'(req_ready), 80'(0));
    cycle();
    flush = 0; req_valid = 0;
    #1;
    chk("s4_valid_after", 80'(rsp_valid), 80'(0));
    chk("s4_ready_after", 80'(req_ready), 80'(1));
    rsp_ready = 1; cycle(); cycle();

    // Load and fetch the same address on the same edge
    ld_en = 1; ld_addr = 64'd143; ld_data = 8'h61;
    req_valid = 1; req_pc = 64'd143; rsp_ready = 1;
    cycle();
    ld_en = 0;
    #1 chk("s5_old_byte", 80'(rsp_byte0), 80'(8'h00));
    cycle();
    req_valid = 0;
    #1 chk("s5_new_byte", 80'(rsp_byte0), 80'(8'h61));
    cycle();

    // Asynchronous reset in the middle of a stall
    rsp_ready = 0; req_valid = 1; req_pc = 64'd200; cycle();
    req_pc = 64'd210; cycle();
    req_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("s6_valid_async", 80'(rsp_valid), 80'(0));
    chk("s6_ready_async", 80'(req_ready), 80'(1));
    chk("s6_pc_async",    80'(rsp_pc),    80'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1; req_pc = 64'd112; rsp_ready = 1;
    cycle();
    req_valid = 0;
    #1 chk("s6_mem_kept", 80'(rsp_byte0), 80'(8'h30));
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_pc    = ($urandom_range(0, 19) == 0) ? {$urandom, $urandom}
                                               : AW'($urandom_range(0, DEPTH + 12));
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      ld_en     = ($urandom_range(0, 3) == 0);
      ld_addr   = AW'($urandom_range(0, DEPTH + 8));
      ld_data   = 8'($urandom);
      cycle();
    end
    flush = 0; ld_en = 0; req_valid = 0; rsp_ready = 1;
    cycle(); cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
